// File: rtl/inst_fetch_buffer.sv
// Fetch-to-decode decoupling FIFO of {pc, inst} pairs with flush and sticky halt.
// Optional zero-latency bypass through an empty buffer: define IFB_BYPASS_EN.
module inst_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int IW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   halt_req,
  input  logic                   in_valid,
  input  logic [AW-1:0]          in_pc,
  input  logic [IW-1:0]          in_inst,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [AW-1:0]          out_pc,
  output logic [IW-1:0]          out_inst,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   halted
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int PW   = IDXW + 1;

  typedef enum logic {RUN, HALT} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW+IW-1:0] mem_q [DEPTH];
  logic [AW+IW-1:0] head;

  logic running, empty, full, bypass, bypass_take, push, pop, wr_en;

  assign running = (state_q == RUN);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IDXW-1:0] == rd_ptr_q[IDXW-1:0]) &&
                   (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
  assign head    = mem_q[rd_ptr_q[IDXW-1:0]];

`ifdef IFB_BYPASS_EN
  assign bypass = empty & running & ~flush & in_valid;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready    = ~full & running;
  assign out_valid   = (~empty & running) | bypass;
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  // A bypassed entry taken by decode in the same cycle never touches storage.
  assign bypass_take = bypass & out_ready;
  assign wr_en       = running & ~flush & push & ~halt_req & ~bypass_take;
  assign count       = wr_ptr_q - rd_ptr_q;
  assign halted      = ~running;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    out_pc   = '0;
    out_inst = '0;
    if (bypass) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end else if (out_valid) begin
      {out_pc, out_inst} = head;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (running) begin
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end else begin
        if (wr_en)               wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop && !bypass_take) rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (halt_req) state_d = HALT;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; outputs are masked by out_valid so stale words never leak.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[IDXW-1:0]] <= {in_pc, in_inst};
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_inst_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        flush, halt_req, in_valid, out_ready;
  logic [31:0] in_pc, in_inst;
  logic        in_ready, out_valid, halted;
  logic [31:0] out_pc, out_inst;
  logic [2:0]  count;

  inst_fetch_buffer #(.DEPTH(DEPTH), .AW(32), .IW(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .halt_req(halt_req),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .count(count), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents as a queue of {pc, inst}, plus a halt flag.
  logic [63:0] m_q[$];
  logic        m_halted;

`ifdef IFB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_idle();
    flush = 0; halt_req = 0; in_valid = 0; out_ready = 0; in_pc = '0; in_inst = '0;
  endtask

  // Drive one cycle, check combinational outputs against the model, advance both.
  task automatic step(input logic f, input logic h, input logic iv,
                      input logic [31:0] pc, input logic [31:0] inst, input logic ordy);
    logic run, byp, e_ov, e_ir, do_pop, do_push;
    logic [63:0] e_out;
    flush = f; halt_req = h; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    @(negedge clk);
    run   = !m_halted;
    byp   = BYP && run && (m_q.size() == 0) && !f && iv;
    e_ov  = (run && m_q.size() != 0) || byp;
    e_ir  = run && (m_q.size() < DEPTH);
    e_out = byp ? {pc, inst} : ((run && m_q.size() != 0) ? m_q[0] : 64'd0);
    check("m_in_ready",  in_ready,  e_ir);
    check("m_out_valid", out_valid, e_ov);
    check("m_out_pc",    out_pc,    e_out[63:32]);
    check("m_out_inst",  out_inst,  e_out[31:0]);
    check("m_count",     count,     m_q.size());
    check("m_halted",    halted,    m_halted);
    if (run) begin
      if (f) begin
        m_q.delete();
      end else if (!(byp && ordy)) begin
        do_pop  = e_ov && ordy;
        do_push = iv && e_ir && !h;
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back({pc, inst});
      end
      if (h) m_halted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between edges; effects checked before any clock edge.
  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #1;
    check("rst_halted",    halted,    1'b0);
    check("rst_count",     count,     3'd0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc",    out_pc,    32'd0);
    check("rst_out_inst",  out_inst,  32'd0);
    m_q.delete();
    m_halted = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        f, h, iv;
    logic [31:0] pc, inst;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [31:0] e_pc, e_inst;
    logic [2:0]  e_cnt;
    logic        e_halt;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int halt_age;
    //           f  h  iv  pc     inst          ordy  ir ov  e_pc   e_inst        cnt halt
    vecs[0]  = '{0, 0, 1, 32'h00, 32'h00000013, 0,    1, 1, 32'h00, 32'h00000013, 1, 0};
    vecs[1]  = '{0, 0, 1, 32'h04, 32'h00100093, 0,    1, 1, 32'h00, 32'h00000013, 2, 0};
    vecs[2]  = '{0, 0, 1, 32'h08, 32'h00200113, 0,    1, 1, 32'h00, 32'h00000013, 3, 0};
    vecs[3]  = '{0, 0, 1, 32'h0C, 32'h00300193, 0,    0, 1, 32'h00, 32'h00000013, 4, 0};
    vecs[4]  = '{0, 0, 1, 32'h10, 32'h00400213, 0,    0, 1, 32'h00, 32'h00000013, 4, 0};
    vecs[5]  = '{0, 0, 0, 32'h00, 32'h00000000, 1,    1, 1, 32'h04, 32'h00100093, 3, 0};
    vecs[6]  = '{0, 0, 0, 32'h00, 32'h00000000, 1,    1, 1, 32'h08, 32'h00200113, 2, 0};
    vecs[7]  = '{0, 0, 0, 32'h00, 32'h00000000, 1,    1, 1, 32'h0C, 32'h00300193, 1, 0};
    vecs[8]  = '{0, 0, 0, 32'h00, 32'h00000000, 1,    1, 0, 32'h00, 32'h00000000, 0, 0};
    vecs[9]  = '{0, 0, 1, 32'h20, 32'h11111111, 0,    1, 1, 32'h20, 32'h11111111, 1, 0};
    vecs[10] = '{0, 0, 1, 32'h24, 32'h22222222, 0,    1, 1, 32'h20, 32'h11111111, 2, 0};
    vecs[11] = '{0, 0, 1, 32'h28, 32'h33333333, 0,    1, 1, 32'h20, 32'h11111111, 3, 0};
    vecs[12] = '{1, 0, 1, 32'h40, 32'h44444444, 0,    1, 0, 32'h00, 32'h00000000, 0, 0};
    vecs[13] = '{0, 0, 1, 32'h80, 32'h88888888, 0,    1, 1, 32'h80, 32'h88888888, 1, 0};
    vecs[14] = '{0, 0, 1, 32'h84, 32'h99999999, 0,    1, 1, 32'h80, 32'h88888888, 2, 0};
    vecs[15] = '{0, 1, 0, 32'h00, 32'h00000000, 0,    0, 0, 32'h00, 32'h00000000, 2, 1};
    vecs[16] = '{1, 0, 1, 32'h90, 32'hAAAAAAAA, 1,    0, 0, 32'h00, 32'h00000000, 2, 1};

    m_q.delete();
    m_halted = 1'b0;
    set_idle();
    rst_n = 1'b1;
    #2;
    do_reset();

    // Directed table: post-edge state sampled with inputs idled.
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].f, vecs[i].h, vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].ordy);
      set_idle();
      #1;
      check($sformatf("v%0d_in_ready", i),  in_ready,  vecs[i].e_ir);
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("v%0d_out_pc", i),    out_pc,    vecs[i].e_pc);
      check($sformatf("v%0d_out_inst", i),  out_inst,  vecs[i].e_inst);
      check($sformatf("v%0d_count", i),     count,     vecs[i].e_cnt);
      check($sformatf("v%0d_halted", i),    halted,    vecs[i].e_halt);
    end
    do_reset();

    // Streaming push+pop across 10 entries: head advances by 4, count steady at 1.
    step(0, 0, 1, 32'h100, 32'h0000_0100, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 1, 32'h100 + 32'(4 * i), 32'h0000_0100 + 32'(i), 1);
      set_idle();
      #1;
      check("stream_head", out_pc, 32'h100 + 32'(4 * i));
      check("stream_count", count, 3'd1);
    end
    step(0, 0, 0, 32'h0, 32'h0, 1);
    check("stream_drained", count, 3'd0);

    // Empty buffer with in_valid and out_ready in the same cycle.
    in_valid = 1; in_pc = 32'h10; in_inst = 32'h0000_0513; out_ready = 1;
    #1;
    check("byp_out_valid", out_valid, BYP);
    check("byp_out_pc", out_pc, BYP ? 32'h10 : 32'h0);
    step(0, 0, 1, 32'h10, 32'h0000_0513, 1);
    set_idle();
    #1;
    check("byp_count_after", count, BYP ? 3'd0 : 3'd1);
    check("byp_out_valid_after", out_valid, !BYP);
    do_reset();

    // Randomized traffic against the model.
    halt_age = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_halted) halt_age++;
      if (halt_age > 3) begin
        do_reset();
        halt_age = 0;
      end
      step($urandom_range(15) == 0, $urandom_range(63) == 0, $urandom_range(9) < 7,
           $urandom, $urandom, $urandom_range(9) < 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
